// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
// The watchdog (macro WB_ARB_TIMEOUT_EN) uses WDOG_W-bit counting.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  localparam int WDOG_W = 16;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotate-priority selector: first set req bit at or after
// rr_ptr, wrapping modulo N_REQ.
module rr_priority_select #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);

  localparam int IDW = $clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  logic [IDW:0]       sum_s;

  // Rotate requests so bit 0 is the master at rr_ptr, then take the first set bit.
  always_comb begin
    dbl_s  = {req, req} >> rr_ptr;
    rot_s  = dbl_s[N_REQ-1:0];
    valid  = 1'b0;
    sum_s  = '0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && rot_s[k]) begin
        valid = 1'b1;
        sum_s = {1'b0, rr_ptr} + (IDW+1)'(k);
      end else begin
        valid = valid;
      end
    end
    if (sum_s >= (IDW+1)'(N_REQ)) begin
      winner = IDW'(sum_s - (IDW+1)'(N_REQ));
    end else begin
      winner = IDW'(sum_s);
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone bus arbiter with registered one-hot grant and no preemption.
// Optional grant watchdog enabled by macro WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
  import wb_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     s_ack,
  input  logic                     s_err,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid,
  output logic                     tout_err
);

  localparam int IDW = $clog2(N_REQ);

  arb_state_e       state_r, state_nxt_s;
  logic [IDW-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [IDW-1:0]   win_idx_s, gnt_id_nxt_s, id_inc_s;
  logic             win_valid_s;
  logic [N_REQ-1:0] gnt_nxt_s;
  logic             gnt_valid_nxt_s;
  logic             held_s;

  rr_priority_select #(
    .N_REQ (N_REQ)
  ) u_sel (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .winner (win_idx_s),
    .valid  (win_valid_s)
  );

  assign held_s   = req[gnt_id];
  assign id_inc_s = (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + IDW'(1);

`ifdef WB_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] wd_cnt_r, wd_cnt_nxt_s;
  logic              tout_nxt_s;

  // Watchdog age of the current grant; the pulse fires when the age reaches TIMEOUT_CYCLES-1.
  always_comb begin
    wd_cnt_nxt_s = '0;
    tout_nxt_s   = 1'b0;
    if (state_r == GRANT && state_nxt_s == GRANT) begin
      if (s_ack || s_err) begin
        wd_cnt_nxt_s = '0;
      end else begin
        wd_cnt_nxt_s = wd_cnt_r + WDOG_W'(1);
      end
      tout_nxt_s = (wd_cnt_nxt_s == WDOG_W'(TIMEOUT_CYCLES-1));
    end else begin
      wd_cnt_nxt_s = '0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= '0;
      tout_err <= 1'b0;
    end else begin
      wd_cnt_r <= wd_cnt_nxt_s;
      tout_err <= tout_nxt_s;
    end
  end
`else
  logic unused_s;
  assign unused_s = s_ack ^ s_err ^ (TIMEOUT_CYCLES == 0);
  assign tout_err = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      rr_ptr_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      gnt       <= gnt_nxt_s;
      gnt_id    <= gnt_id_nxt_s;
      gnt_valid <= gnt_valid_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
    end
  end

  // Next-state logic; a grant is only ever left by its owner dropping req.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (!held_s) begin
          state_nxt_s = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (tout_err) begin
          state_nxt_s = FLUSH;
`endif
        end else begin
          state_nxt_s = GRANT;
        end
      end
      FLUSH: begin
`ifdef WB_ARB_TIMEOUT_EN
        if (!held_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FLUSH;
        end
`else
        state_nxt_s = IDLE;
`endif
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the grant outputs and the round-robin pointer.
  always_comb begin
    gnt_nxt_s       = gnt;
    gnt_id_nxt_s    = gnt_id;
    gnt_valid_nxt_s = gnt_valid;
    rr_ptr_nxt_s    = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          gnt_nxt_s       = N_REQ'(1) << win_idx_s;
          gnt_id_nxt_s    = win_idx_s;
          gnt_valid_nxt_s = 1'b1;
        end else begin
          gnt_nxt_s       = '0;
          gnt_id_nxt_s    = '0;
          gnt_valid_nxt_s = 1'b0;
        end
      end
      GRANT, FLUSH: begin
        if (!held_s) begin
          gnt_nxt_s       = '0;
          gnt_id_nxt_s    = '0;
          gnt_valid_nxt_s = 1'b0;
          rr_ptr_nxt_s    = id_inc_s;
        end else begin
          gnt_nxt_s       = gnt;
          gnt_id_nxt_s    = gnt_id;
          gnt_valid_nxt_s = gnt_valid;
        end
      end
      default: begin
        gnt_nxt_s       = '0;
        gnt_id_nxt_s    = '0;
        gnt_valid_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/wb_arbiter_rr.md
WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 SHALL have parameter N_REQ, default 4, the number of requesting bus masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, the watchdog limit in clock cycles (2..65535; used only when WB_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have one clock and a synchronous, active-high reset, declared first in the port list.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port req, input, N_REQ bits: bit i is the CYC of master i.
REQ-007 SHALL have port s_ack, input, 1 bit: ACK from the shared slave path.
REQ-008 SHALL have port s_err, input, 1 bit: ERR from the shared slave path.
REQ-009 SHALL have port gnt, output, N_REQ bits: one-hot grant, or all zero.
REQ-010 SHALL have port gnt_id, output, $clog2(N_REQ) bits: index of the granted master; valid only while gnt_valid is high.
REQ-011 SHALL have port gnt_valid, output, 1 bit: high while a grant is held.
REQ-012 SHALL have port tout_err, output, 1 bit: single-cycle watchdog error, routed to the granted master's ERR.

Function
REQ-013 SHALL implement states IDLE, GRANT and FLUSH; FLUSH is reachable only when WB_ARB_TIMEOUT_EN is defined.
REQ-014 SHALL, in IDLE with req nonzero, select the first set req bit at or after rr_ptr, wrapping modulo N_REQ, and enter GRANT with gnt, gnt_id and gnt_valid registered: 1 cycle from req to gnt.
REQ-015 SHALL remain in GRANT while req[gnt_id] is high, whatever the other req bits do; there is no preemption.
REQ-016 SHALL, in GRANT with req[gnt_id] low, go to IDLE, clear gnt and gnt_valid on the next edge, and set rr_ptr to (gnt_id+1) mod N_REQ.
REQ-017 SHALL not re-grant in the cycle grant is released; the minimum bus turnaround is 1 idle cycle.
REQ-018 SHALL keep gnt one-hot or zero at all times, with gnt_valid equal to the OR of gnt.
REQ-019 SHALL ignore s_ack and s_err in IDLE.
REQ-020 SHALL make the master at rr_ptr the winner when several req bits rise in the same cycle.
REQ-021 SHALL, when a master re-asserts req in the cycle after its own release, grant it only if no higher-priority (per rr_ptr) request is pending.

Reset
REQ-022 SHALL, with rst high at a clock edge, force: state IDLE, gnt=0, gnt_id=0, gnt_valid=0, tout_err=0, rr_ptr=0, watchdog count=0.
REQ-023 SHALL, on reset asserted mid-grant, drop gnt on the next edge regardless of req, ack or err.
REQ-024 SHALL not arbitrate in the first cycle after rst deasserts unless req is already high; in that case the grant follows REQ-014.

Configuration
REQ-025 SHALL use macro WB_ARB_TIMEOUT_EN to enable the watchdog.
REQ-026 SHALL, when WB_ARB_TIMEOUT_EN is defined: a 16-bit counter clears on GRANT entry and on any s_ack or s_err, and increments each other GRANT cycle.
REQ-027 SHALL, when WB_ARB_TIMEOUT_EN is defined and the counter reaches TIMEOUT_CYCLES-1 without ack or err: pulse tout_err for 1 cycle, then enter FLUSH.
REQ-028 SHALL, in FLUSH, keep gnt held with tout_err low, and go to IDLE when req[gnt_id] drops; rr_ptr updates as in REQ-016.
REQ-029 SHALL, when WB_ARB_TIMEOUT_EN is not defined, have no counter or FLUSH logic and tie tout_err to 0.

Structure
REQ-030 SHALL have a shared package wb_arbiter_pkg holding the state enum typedef (IDLE, GRANT, FLUSH) and the watchdog counter width constant (16).
REQ-031 SHALL place the purely combinational rotate-priority selector (req, rr_ptr -> winner index and valid) in sub-module rr_priority_select.

Verification
REQ-032 SHALL verify single request: req=0b0100 from reset -> gnt=0b0100 and gnt_id=2 one cycle later; req drop -> gnt=0 next cycle, rr_ptr=3.
REQ-033 SHALL verify fairness: req=0b1111 held, each master releasing after 3 cycles -> grant order 0,1,2,3,0 with 1 idle cycle between grants.
REQ-034 SHALL verify no preemption: master 1 granted, then req[0] rises -> gnt stays 0b0010 until req[1] drops, then gnt=0b0001.
REQ-035 SHALL verify mid-grant reset: gnt=0b1000, rst pulsed 1 cycle -> gnt=0 and gnt_valid=0 next edge; with req=0b1000 still high, re-grant to 3 one cycle after rst drops.
REQ-036 SHALL verify the watchdog (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): grant held with no ack -> tout_err high exactly in the 8th GRANT cycle; req drop -> IDLE; an ack at cycle 5 restarts the count.
REQ-037 SHALL verify the macro is off: same stimulus as REQ-036 -> tout_err never asserts and the grant holds indefinitely.
